gmii_rx_framer: RTL and testbench
=================================

# gmii_rx_framer

Receive-side framer that converts raw GMII receive signals into the byte stream consumed by the downstream CRC-32 checker. It strips preamble and SFD and marks start and end of packet. It also flags receive errors, and optionally length violations, on the final beat. Output is one registered beat per received data byte, at constant latency.

## Interface
- P_MIN_PREAMBLE, 1: minimum number of 0x55 bytes required before the SFD.
- P_MIN_LEN, 64: minimum frame length in bytes, FCS included; used only with length check.
- P_MAX_LEN, 1518: maximum frame length in bytes, FCS included; used only with length check.
- clk  in  1  single clock, GMII receive clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rx_er  in  1  receive error.
- gmii_rxd  in  8  receive data.
- stream_out_startofpacket  out  1  first data byte of frame.
- stream_out_endofpacket  out  1  last byte of frame (last FCS byte).
- stream_out_valid  out  1  beat valid.
- stream_out_data  out  8  data byte, unmodified bit order.
- stream_out_error  out  1  frame error; meaningful only on the endofpacket beat.

## Operation
- GMII inputs are sampled on rising clk. There is no backpressure, so output beats are produced unconditionally.
- State machine states: IDLE, PREAMBLE, DATA, DROP. The reset state is DROP.
- **IDLE**
  - rx_dv=1 and rxd=0x55: go to PREAMBLE with preamble count=1.
  - rx_dv=1 and rxd=0xD5 with P_MIN_PREAMBLE=0: go to DATA.
  - rx_dv=1 with any other byte: go to DROP.
- **PREAMBLE**
  - rxd=0x55: increment the preamble count, saturating at 15.
  - rxd=0xD5 with count ≥ P_MIN_PREAMBLE: go to DATA, set the first flag, clear the sticky error and the length counter.
  - Any other byte, or 0xD5 with count too low: go to DROP.
  - rx_dv=0: go to IDLE; nothing is emitted.
- **DATA**
  - Each byte with rx_dv=1 loads a one-byte hold register.
  - If the hold register is already full, its previous content is emitted first: valid=1, sop equal to the first flag, eop=0, error=0. The first flag is then cleared.
- **End of frame (DATA with rx_dv=0)**
  - Hold full: emit the held byte with eop=1, sop equal to the first flag, and error equal to the final error term. Then go to IDLE.
  - Hold empty (SFD followed directly by rx_dv=0): emit nothing and go to IDLE.
- **Errors**
  - rx_er=1 while rx_dv=1 in DATA sets the sticky error flag.
  - rx_er with rx_dv=0 is ignored (carrier extension or false carrier).
  - The final error term is the sticky flag, ORed with the length error when length check is compiled in.
- **DROP**
  - Wait for rx_dv=0, then go to IDLE. No beats are emitted.
- **Length counter**
  - Width is $clog2(P_MAX_LEN+2).
  - It counts bytes loaded in DATA and saturates at all-ones.
  - Frames are never truncated.
- **Single-byte frame:** one beat with sop=1 and eop=1.
- **Inter-frame gap:** a gap of one rx_dv=0 cycle is sufficient. The next preamble is accepted on the following cycle.

## Timing
- All outputs are registered and reset to 0 asynchronously. The hold register, flags and counters also reset to 0.
- **Latency:** a byte present on gmii_rxd before edge t appears on the outputs after edge t+1. This 2-cycle latency is constant for every beat, including the eop beat.
- **Output valid pattern:**
  - Valid is high for exactly one cycle per data byte.
  - Beats within a frame are contiguous.
  - Valid returns to 0 the cycle after the eop beat unless a new beat is due.
- **Reset mid-frame:**
  - Outputs go to 0 immediately.
  - After release the block starts in DROP, so the remainder of the frame in progress is discarded.
  - A partial frame is never emitted with eop.
- **Simultaneous events:** rx_er together with the final rx_dv=1 byte counts toward the error. The eop beat carries it.

## Configuration
- RX_LEN_CHECK_EN defined: at end of frame, error is also set if the length is < P_MIN_LEN or > P_MAX_LEN.
- RX_LEN_CHECK_EN undefined: the length comparison logic is absent and error reflects only rx_er. The byte counter is still used for saturation only if needed by synthesis; it may be removed.

## Structure
- Shared package mac_pkg holds:
  - the stream_t packed struct (startofpacket, endofpacket, valid, data, error);
  - constants C_PREAMBLE=8'h55 and C_SFD=8'hD5;
  - the framer state enum.
- The output register uses stream_t.
- No sub-module; a single module is natural.

## Test plan
- **Nominal frame.** Stimulus: 7×0x55, 0xD5, 64 bytes 0x00..0x3F, then rx_dv=0. Required response: 64 contiguous beats; sop on 0x00, eop on 0x3F, error=0; first beat 2 cycles after 0x00 is on rxd.
- **Receive error.** Stimulus: same frame with rx_er=1 for one cycle on byte 10. Required response: all 64 beats emitted; error=1 only on the eop beat.
- **Bad SFD.** Stimulus: preamble followed by 0x5D instead of 0xD5, then a 1-cycle gap and a nominal frame. Required response: no beats for the first frame; the second frame is received exactly as in the nominal case.
- **Degenerate frames.** Stimulus A: SFD then rx_dv=0 → no beats. Stimulus B: SFD, 0xAB, rx_dv=0 → one beat, data 0xAB, sop=eop=1.
- **Length check, RX_LEN_CHECK_EN defined.** 63-byte frame → error=1 on eop. 1519-byte frame → error=1. 1518- and 64-byte frames → error=0.
- **Length check, RX_LEN_CHECK_EN undefined.** 63-byte frame → error=0.
- **Reset mid-frame.** Stimulus: rst_n asserted at byte 20 and released while rx_dv=1. Required response: outputs 0 immediately; no further beats for that frame; the next frame is received normally.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC receive-path types: stream beat struct, GMII framing constants and framer states.
package mac_pkg;

  localparam logic [7:0] C_PREAMBLE = 8'h55;
  localparam logic [7:0] C_SFD      = 8'hD5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } framer_state_t;

  typedef struct packed {
    logic       startofpacket;
    logic       endofpacket;
    logic       valid;
    logic [7:0] data;
    logic       error;
  } stream_t;

  // Preamble counter only needs to prove "enough" 0x55 bytes, so it sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/gmii_rx_framer_if.sv
// GMII receive inputs and the framed byte stream output of gmii_rx_framer.
interface gmii_rx_framer_if;

  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;

  logic       stream_out_startofpacket;
  logic       stream_out_endofpacket;
  logic       stream_out_valid;
  logic [7:0] stream_out_data;
  logic       stream_out_error;

  // master: the framer (consumes GMII, sources the stream)
  modport master (
    input  gmii_rx_dv,
    input  gmii_rx_er,
    input  gmii_rxd,
    output stream_out_startofpacket,
    output stream_out_endofpacket,
    output stream_out_valid,
    output stream_out_data,
    output stream_out_error
  );

  // slave: the PHY-side driver and the stream consumer
  modport slave (
    output gmii_rx_dv,
    output gmii_rx_er,
    output gmii_rxd,
    input  stream_out_startofpacket,
    input  stream_out_endofpacket,
    input  stream_out_valid,
    input  stream_out_data,
    input  stream_out_error
  );

endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, emits one beat per data byte with sop/eop/error.
// Optional length check on the final beat is compiled in with RX_LEN_CHECK_EN.
module gmii_rx_framer
  import mac_pkg::*;
#(
  parameter int unsigned P_MIN_PREAMBLE = 1,
  parameter int unsigned P_MIN_LEN      = 64,
  parameter int unsigned P_MAX_LEN      = 1518
) (
  input  logic             clk,
  input  logic             rst_n,
  gmii_rx_framer_if.master bus
);

  framer_state_t state_reg, state_next;
  logic [3:0]    pre_cnt_reg, pre_cnt_next;
  logic [7:0]    hold_reg, hold_next;
  logic          hold_full_reg, hold_full_next;
  logic          first_reg, first_next;
  logic          sticky_reg, sticky_next;
  logic          final_err;
  stream_t       out_reg, out_next;

  logic       rx_dv;
  logic       rx_er;
  logic [7:0] rxd;

  assign rx_dv = bus.gmii_rx_dv;
  assign rx_er = bus.gmii_rx_er;
  assign rxd   = bus.gmii_rxd;

`ifdef RX_LEN_CHECK_EN
  localparam int LEN_W = $clog2(P_MAX_LEN + 2);

  logic [LEN_W-1:0] len_reg, len_next;
  logic             len_err;

  // Counter saturates at all-ones, which is always above P_MAX_LEN.
  assign len_err   = (32'(len_reg) < P_MIN_LEN) || (32'(len_reg) > P_MAX_LEN);
  assign final_err = sticky_reg | len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg <= '0;
    end else begin
      len_reg <= len_next;
    end
  end
`else
  assign final_err = sticky_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= DROP;
      pre_cnt_reg   <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      first_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
      out_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pre_cnt_reg   <= pre_cnt_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      first_reg     <= first_next;
      sticky_reg    <= sticky_next;
      out_reg       <= out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pre_cnt_next   = pre_cnt_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    first_next     = first_reg;
    sticky_next    = sticky_reg;
    out_next       = '0;
`ifdef RX_LEN_CHECK_EN
    len_next       = len_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (rx_dv) begin
          if (rxd == C_PREAMBLE) begin
            state_next   = PREAMBLE;
            pre_cnt_next = 4'd1;
          end else if ((rxd == C_SFD) && (P_MIN_PREAMBLE == 0)) begin
            state_next     = DATA;
            first_next     = 1'b1;
            sticky_next    = 1'b0;
            hold_full_next = 1'b0;
`ifdef RX_LEN_CHECK_EN
            len_next       = '0;
`endif
          end else begin
            state_next = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (!rx_dv) begin
          state_next = IDLE;
        end else if (rxd == C_PREAMBLE) begin
          pre_cnt_next = sat_inc4(pre_cnt_reg);
        end else if ((rxd == C_SFD) && ({28'd0, pre_cnt_reg} >= P_MIN_PREAMBLE)) begin
          state_next     = DATA;
          first_next     = 1'b1;
          sticky_next    = 1'b0;
          hold_full_next = 1'b0;
`ifdef RX_LEN_CHECK_EN
          len_next       = '0;
`endif
        end else begin
          state_next = DROP;
        end
      end

      DATA: begin
        if (rx_dv) begin
          // The one-byte hold delays emission so the last byte can carry eop.
          if (hold_full_reg) begin
            out_next.valid         = 1'b1;
            out_next.startofpacket = first_reg;
            out_next.data          = hold_reg;
            first_next             = 1'b0;
          end
          hold_next      = rxd;
          hold_full_next = 1'b1;
          sticky_next    = sticky_reg | rx_er;
`ifdef RX_LEN_CHECK_EN
          len_next       = (len_reg == '1) ? len_reg : len_reg + 1'b1;
`endif
        end else begin
          if (hold_full_reg) begin
            out_next.valid         = 1'b1;
            out_next.startofpacket = first_reg;
            out_next.endofpacket   = 1'b1;
            out_next.data          = hold_reg;
            out_next.error         = final_err;
          end
          hold_full_next = 1'b0;
          first_next     = 1'b0;
          state_next     = IDLE;
        end
      end

      DROP: begin
        if (!rx_dv) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = DROP;
      end
    endcase
  end

  assign bus.stream_out_startofpacket = out_reg.startofpacket;
  assign bus.stream_out_endofpacket   = out_reg.endofpacket;
  assign bus.stream_out_valid         = out_reg.valid;
  assign bus.stream_out_data          = out_reg.data;
  assign bus.stream_out_error         = out_reg.error;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Self-checking bench for gmii_rx_framer: directed and random frames against a frame-level model.
module tb_gmii_rx_framer;
  import mac_pkg::*;

  localparam int unsigned MIN_PRE = 1;
  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1518;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gmii_rx_framer_if bus();

  gmii_rx_framer #(
    .P_MIN_PREAMBLE(MIN_PRE),
    .P_MIN_LEN(MIN_LEN),
    .P_MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic       sop;
    logic       eop;
    logic [7:0] data;
    logic       err;
  } beat_t;

  beat_t      exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] payload [0:2047];
  bit         er_arr  [0:2047];

  always @(posedge clk) cyc <= cyc + 1;

  // Compare this cycle's output against the model's schedule of beats.
  task automatic check_cycle();
    logic  exp_v;
    beat_t e;
    exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    checks++;
    assert (bus.stream_out_valid === exp_v) else begin
      errors++;
      $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, bus.stream_out_valid, exp_v);
    end
    if (exp_v) begin
      e = exp_q.pop_front();
      if (bus.stream_out_valid === 1'b1) begin
        checks++;
        assert ({bus.stream_out_startofpacket, bus.stream_out_endofpacket,
                 bus.stream_out_data, bus.stream_out_error} === {e.sop, e.eop, e.data, e.err}) else begin
          errors++;
          $error("FAIL beat cyc=%0d observed sop=%b eop=%b data=%h err=%b expected sop=%b eop=%b data=%h err=%b",
                 cyc, bus.stream_out_startofpacket, bus.stream_out_endofpacket, bus.stream_out_data,
                 bus.stream_out_error, e.sop, e.eop, e.data, e.err);
        end
      end
    end
  endtask

  task automatic step(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    check_cycle();
    bus.gmii_rx_dv = dv;
    bus.gmii_rx_er = er;
    bus.gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  // Frame-level model: accepted iff enough preamble and a valid SFD; error from rx_er over data (and length).
  task automatic send_frame(input string tag, input int npre, input logic [7:0] sfd, input int n, input int gap);
    bit    accept;
    bit    ferr;
    beat_t b;
    accept = (sfd == C_SFD) && (npre >= int'(MIN_PRE));
    ferr = 1'b0;
    for (int i = 0; i < n; i++) ferr |= er_arr[i];
`ifdef RX_LEN_CHECK_EN
    if (n < int'(MIN_LEN) || n > int'(MAX_LEN)) ferr = 1'b1;
`endif
    for (int p = 0; p < npre; p++) step(1'b1, 1'($urandom_range(0, 1)), C_PREAMBLE);
    step(1'b1, 1'b0, sfd);
    for (int i = 0; i < n; i++) begin
      step(1'b1, er_arr[i], payload[i]);
      if (accept) begin
        b.cyc  = cyc + 2;
        b.sop  = (i == 0);
        b.eop  = (i == n - 1);
        b.data = payload[i];
        b.err  = (i == n - 1) ? ferr : 1'b0;
        exp_q.push_back(b);
      end
    end
    idle(gap);
    $display("frame %s: pre=%0d sfd=%h len=%0d accepted=%0d err=%0d", tag, npre, sfd, n, accept, ferr);
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++) begin
      payload[i] = 8'(i);
      er_arr[i]  = 1'b0;
    end
  endtask

  initial begin
    int         n;
    int         npre;
    logic [7:0] sfd;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'h00;

    #3;
    checks++;
    assert ({bus.stream_out_startofpacket, bus.stream_out_endofpacket, bus.stream_out_valid,
             bus.stream_out_data, bus.stream_out_error} === 12'h000) else begin
      errors++;
      $error("FAIL reset_outputs observed=%b expected=0", bus.stream_out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    fill_seq(64);
    send_frame("nominal", 7, C_SFD, 64, 1);

    fill_seq(64);
    er_arr[10] = 1'b1;
    send_frame("rx_error", 7, C_SFD, 64, 1);

    fill_seq(64);
    send_frame("bad_sfd", 7, 8'h5D, 64, 1);
    send_frame("after_bad_sfd", 7, C_SFD, 64, 1);

    send_frame("degenerate_a", 7, C_SFD, 0, 1);
    payload[0] = 8'hAB;
    er_arr[0]  = 1'b0;
    send_frame("degenerate_b", 7, C_SFD, 1, 1);
    send_frame("no_preamble", 0, C_SFD, 4, 1);

    fill_seq(1519);
    send_frame("len63", 7, C_SFD, 63, 1);
    send_frame("len64", 7, C_SFD, 64, 1);
    send_frame("len1518", 7, C_SFD, 1518, 1);
    send_frame("len1519", 7, C_SFD, 1519, 2);

    // Reset mid-frame: outputs clear at once, rest of frame discarded, next frame normal.
    fill_seq(40);
    for (int p = 0; p < 7; p++) step(1'b1, 1'b0, C_PREAMBLE);
    step(1'b1, 1'b0, C_SFD);
    for (int i = 0; i < 40; i++) begin
      beat_t b;
      step(1'b1, 1'b0, payload[i]);
      if (i < 20) begin
        b.cyc = cyc + 2; b.sop = (i == 0); b.eop = 1'b0; b.data = payload[i]; b.err = 1'b0;
        exp_q.push_back(b);
      end
      if (i == 20) begin
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert ({bus.stream_out_startofpacket, bus.stream_out_endofpacket, bus.stream_out_valid,
                 bus.stream_out_data, bus.stream_out_error} === 12'h000) else begin
          errors++;
          $error("FAIL reset_midframe observed valid=%b data=%h expected 0", bus.stream_out_valid, bus.stream_out_data);
        end
        exp_q.delete();
      end
      if (i == 23) rst_n = 1'b1;
    end
    idle(1);
    $display("frame reset_midframe: len=40 reset at byte 20");
    fill_seq(64);
    send_frame("after_reset", 7, C_SFD, 64, 1);

    for (int f = 0; f < 10; f++) begin
      n    = $urandom_range(1, 90);
      npre = $urandom_range(0, 10);
      sfd  = ($urandom_range(0, 4) != 0) ? C_SFD : 8'($urandom);
      if (sfd == C_PREAMBLE) sfd = 8'h5D;
      for (int i = 0; i < n; i++) begin
        payload[i] = 8'($urandom);
        er_arr[i]  = ($urandom_range(0, 40) == 0);
      end
      send_frame("random", npre, sfd, n, $urandom_range(1, 3));
    end

    idle(4);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d pending expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
